// File: rtl/vga_shift_pattern.sv
// Raster timing generator with a white square that moves one pixel per frame
// on a diagonal and bounces off the edges of the active area.
module vga_shift_pattern #(
  parameter int H_TOTAL  = 2199,
  parameter int H_SYNC   = 43,
  parameter int H_START  = 189,
  parameter int H_END    = 2109,
  parameter int V_TOTAL  = 1124,
  parameter int V_SYNC   = 4,
  parameter int V_START  = 40,
  parameter int V_END    = 1120,
  parameter int SQUARE_X = 500,
  parameter int SQUARE_Y = 500,
  parameter int SCREEN_X = H_END - H_START,
  parameter int SCREEN_Y = V_END - V_START
) (
  input  logic       vpg_pclk,
  input  logic       rst,
  output logic       vpg_de,
  output logic       vpg_hs,
  output logic       vpg_vs,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b
);

  localparam logic [11:0] HT     = 12'(H_TOTAL);
  localparam logic [11:0] HS     = 12'(H_SYNC);
  localparam logic [11:0] HB     = 12'(H_START);
  localparam logic [11:0] HE     = 12'(H_END);
  localparam logic [11:0] VT     = 12'(V_TOTAL);
  localparam logic [11:0] VS     = 12'(V_SYNC);
  localparam logic [11:0] VB     = 12'(V_START);
  localparam logic [11:0] VE     = 12'(V_END);
  localparam logic [12:0] SQ_W   = 13'(SQUARE_X);
  localparam logic [12:0] SQ_H   = 13'(SQUARE_Y);
  localparam logic [11:0] X_MAX  = 12'(SCREEN_X - SQUARE_X);
  localparam logic [11:0] Y_MAX  = 12'(SCREEN_Y - SQUARE_Y);
  localparam logic [11:0] ONE    = 12'd1;

  logic [11:0] r_h_cnt, r_v_cnt;
  logic [11:0] r_sq_x, r_sq_y;
  logic        r_dir_x, r_dir_y;   // 1 = moving towards larger coordinate

  logic        w_hs, w_vs, w_de, w_in_sq, w_h_last, w_frame_end;
  logic [11:0] w_px, w_py;

  assign w_h_last    = (r_h_cnt == HT);
  assign w_frame_end = w_h_last && (r_v_cnt == VT);

  assign w_hs = (r_h_cnt <= HS);
  assign w_vs = (r_v_cnt <= VS);
  assign w_de = (r_h_cnt > HB) && (r_h_cnt <= HE) && (r_v_cnt > VB) && (r_v_cnt <= VE);

  // Coordinates wrap outside the active area; in_sq is gated by de so that is harmless.
  assign w_px = r_h_cnt - (HB + ONE);
  assign w_py = r_v_cnt - (VB + ONE);

  assign w_in_sq = w_de &&
                   (w_px >= r_sq_x) && ({1'b0, w_px} < ({1'b0, r_sq_x} + SQ_W)) &&
                   (w_py >= r_sq_y) && ({1'b0, w_py} < ({1'b0, r_sq_y} + SQ_H));

  always_ff @(posedge vpg_pclk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == VT) ? 12'd0 : r_v_cnt + ONE;
    end else begin
      r_h_cnt <= r_h_cnt + ONE;
    end
  end

  // Position only changes on the last clock of a frame, so a frame never tears.
  always_ff @(posedge vpg_pclk or posedge rst) begin
    if (rst) begin
      r_sq_x  <= '0;
      r_sq_y  <= '0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_frame_end) begin
      if (r_dir_x) begin
        if (r_sq_x >= X_MAX - ONE) begin
          r_sq_x  <= X_MAX;
          r_dir_x <= 1'b0;
        end else begin
          r_sq_x <= r_sq_x + ONE;
        end
      end else begin
        if (r_sq_x <= ONE) begin
          r_sq_x  <= '0;
          r_dir_x <= 1'b1;
        end else begin
          r_sq_x <= r_sq_x - ONE;
        end
      end
      if (r_dir_y) begin
        if (r_sq_y >= Y_MAX - ONE) begin
          r_sq_y  <= Y_MAX;
          r_dir_y <= 1'b0;
        end else begin
          r_sq_y <= r_sq_y + ONE;
        end
      end else begin
        if (r_sq_y <= ONE) begin
          r_sq_y  <= '0;
          r_dir_y <= 1'b1;
        end else begin
          r_sq_y <= r_sq_y - ONE;
        end
      end
    end
  end

  always_ff @(posedge vpg_pclk or posedge rst) begin
    if (rst) begin
      vpg_de <= 1'b0;
      vpg_hs <= 1'b0;
      vpg_vs <= 1'b0;
      rgb_r  <= '0;
      rgb_g  <= '0;
      rgb_b  <= '0;
    end else begin
      vpg_de <= w_de;
      vpg_hs <= w_hs;
      vpg_vs <= w_vs;
      rgb_r  <= w_in_sq ? 8'hFF : 8'h00;
      rgb_g  <= w_in_sq ? 8'hFF : 8'h00;
      rgb_b  <= w_in_sq ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_shift_pattern.sv
// Bench for vga_shift_pattern on a shrunken raster (40x20 clocks, 16x12 active,
// 4x4 square) so that timing, pattern, bouncing and reset fit in a short run.
module tb_vga_shift_pattern;

  localparam int HN = 40;  // clocks per line
  localparam int VN = 20;  // lines per frame
  localparam int HB = 9;
  localparam int VB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vpg_de, vpg_hs, vpg_vs;
  logic [7:0] rgb_r, rgb_g, rgb_b;

  int n_chk = 0;
  int n_bad = 0;

  logic        a_de  [0:VN-1][0:HN-1];
  logic        a_hs  [0:VN-1][0:HN-1];
  logic        a_vs  [0:VN-1][0:HN-1];
  logic [23:0] a_rgb [0:VN-1][0:HN-1];

  int minpx, minpy, maxpx, maxpy, nwhite, nde, nblank_bad, nodd;

  vga_shift_pattern #(
    .H_TOTAL(39), .H_SYNC(3), .H_START(9), .H_END(25),
    .V_TOTAL(19), .V_SYNC(1), .V_START(3), .V_END(15),
    .SQUARE_X(4), .SQUARE_Y(4), .SCREEN_X(16), .SCREEN_Y(12)
  ) dut (
    .vpg_pclk(clk), .rst(rst),
    .vpg_de(vpg_de), .vpg_hs(vpg_hs), .vpg_vs(vpg_vs),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One sample per clock, taken on the falling edge; index (v,h) is the counter
  // position that produced the registered output.
  task automatic capture();
    for (int v = 0; v < VN; v++)
      for (int h = 0; h < HN; h++) begin
        @(negedge clk);
        a_de[v][h]  = vpg_de;
        a_hs[v][h]  = vpg_hs;
        a_vs[v][h]  = vpg_vs;
        a_rgb[v][h] = {rgb_r, rgb_g, rgb_b};
      end
  endtask

  task automatic analyze();
    minpx = 99; minpy = 99; maxpx = -1; maxpy = -1;
    nwhite = 0; nde = 0; nblank_bad = 0; nodd = 0;
    for (int v = 0; v < VN; v++)
      for (int h = 0; h < HN; h++) begin
        if (a_de[v][h]) nde++;
        if (!a_de[v][h] && a_rgb[v][h] != 24'h0) nblank_bad++;
        if (a_rgb[v][h] != 24'h0 && a_rgb[v][h] != 24'hFFFFFF) nodd++;
        if (a_rgb[v][h] == 24'hFFFFFF) begin
          nwhite++;
          if (h - HB - 1 < minpx) minpx = h - HB - 1;
          if (v - VB - 1 < minpy) minpy = v - VB - 1;
          if (h - HB - 1 > maxpx) maxpx = h - HB - 1;
          if (v - VB - 1 > maxpy) maxpy = v - VB - 1;
        end
      end
  endtask

  function automatic int tri_pos(input int f, input int r);
    int m;
    m = f % (2 * r);
    return (m <= r) ? m : 2 * r - m;
  endfunction

  function automatic int line_cnt(input int v, input int which);
    int c = 0;
    for (int h = 0; h < HN; h++)
      c += (which == 0) ? int'(a_de[v][h]) : (which == 1) ? int'(a_hs[v][h]) : int'(a_rgb[v][h] == 24'hFFFFFF);
    return c;
  endfunction

  initial begin
    int c, first_de;

    repeat (4) begin
      @(negedge clk);
      chk("rst_outs", int'({vpg_de, vpg_hs, vpg_vs, rgb_r, rgb_g, rgb_b}), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < 26; f++) begin
      capture();
      analyze();
      if (f == 0) begin
        chk("hs_first", int'(a_hs[0][0]), 1);
        chk("hs_last_on", int'(a_hs[0][3]), 1);
        chk("hs_first_off", int'(a_hs[0][4]), 0);
        chk("hs_line_end", int'(a_hs[0][39]), 0);
        chk("hs_wrap", int'(a_hs[1][0]), 1);
        chk("hs_per_line", line_cnt(0, 1), 4);
        first_de = -1;
        for (int h = HN - 1; h >= 0; h--) if (a_de[4][h]) first_de = h;
        chk("de_first_h", first_de, 10);
        chk("de_per_line", line_cnt(4, 0), 16);
        chk("de_line3", line_cnt(3, 0), 0);
        chk("de_line15", line_cnt(15, 0), 16);
        chk("de_line16", line_cnt(16, 0), 0);
        c = 0;
        for (int v = 0; v < VN; v++) if (line_cnt(v, 0) != 0) c++;
        chk("de_lines", c, 12);
        c = 0;
        for (int v = 0; v < VN; v++) c += int'(a_vs[v][20]);
        chk("vs_lines", c, 2);
        chk("vs_line1", int'(a_vs[1][39]), 1);
        chk("vs_line2", int'(a_vs[2][0]), 0);
        chk("f0_px0", int'(a_rgb[4][10]), 24'hFFFFFF);
        chk("f0_px3", int'(a_rgb[4][13]), 24'hFFFFFF);
        chk("f0_px4", int'(a_rgb[4][14]), 0);
        chk("f0_py3_row", line_cnt(7, 2), 4);
        chk("f0_py4_row", line_cnt(8, 2), 0);
      end
      if (f == 1) begin
        chk("f1_py0_row", line_cnt(4, 2), 0);
        chk("f1_px0", int'(a_rgb[5][10]), 0);
        chk("f1_px1", int'(a_rgb[5][11]), 24'hFFFFFF);
        chk("f1_px4", int'(a_rgb[5][14]), 24'hFFFFFF);
        chk("f1_px5", int'(a_rgb[5][15]), 0);
      end
      chk($sformatf("f%0d_x", f), minpx, tri_pos(f, 12));
      chk($sformatf("f%0d_y", f), minpy, tri_pos(f, 8));
      chk($sformatf("f%0d_white", f), nwhite, 16);
      chk($sformatf("f%0d_maxx", f), maxpx, tri_pos(f, 12) + 3);
      chk($sformatf("f%0d_maxy", f), maxpy, tri_pos(f, 8) + 3);
      chk($sformatf("f%0d_de", f), nde, 192);
      chk($sformatf("f%0d_blank", f), nblank_bad + nodd, 0);
    end

    // Reset asserted between clock edges must clear outputs without waiting for a clock.
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", int'({vpg_de, vpg_hs, vpg_vs, rgb_r, rgb_g, rgb_b}), 0);
    repeat (3) @(negedge clk);
    chk("rst_hold", int'({vpg_de, vpg_hs, vpg_vs, rgb_r, rgb_g, rgb_b}), 0);
    rst = 1'b0;
    capture();
    analyze();
    chk("rr_hs_first", int'(a_hs[0][0]), 1);
    chk("rr_x", minpx, 0);
    chk("rr_y", minpy, 0);
    chk("rr_white", nwhite, 16);
    chk("rr_de", nde, 192);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=stalled exp=finish");
    $fatal(1, "timeout");
  end

endmodule
